// File: rtl/data_mem_if.sv
// Data bus between the load/store unit (master) and a data memory responder (slave).
// Request payload is held stable by the master until it sees gnt.
interface data_mem_if;
   logic        data_req_in;
   logic [31:0] data_add_in;
   logic        data_we_in;
   logic [3:0]  data_be_in;
   logic [31:0] data_wdata_in;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;

   modport master (
      output data_req_in, data_add_in, data_we_in, data_be_in, data_wdata_in,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );

   modport slave (
      input  data_req_in, data_add_in, data_we_in, data_be_in, data_wdata_in,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: grants requests after GNT_WAIT wait states, performs byte-enabled
// writes / full-word reads on a single-port RAM and returns in-order responses after LATENCY.
module data_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 1,
   parameter int GNT_WAIT   = 0
) (
   input logic      clk,
   input logic      rst,
   data_mem_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  out_of_range;
   logic                  gnt;
   logic                  accept;
   logic                  unused_addr_lsb;

   assign word_idx        = bus.data_add_in[ADDR_WIDTH+1:2];
   assign out_of_range    = |(bus.data_add_in >> (ADDR_WIDTH + 2));
   assign unused_addr_lsb = ^bus.data_add_in[1:0];
   assign accept          = bus.data_req_in & gnt;
   assign bus.data_gnt_o  = gnt;

   genvar gi;

   generate
      if (GNT_WAIT == 0) begin : g_no_wait
         assign gnt = bus.data_req_in;
      end else begin : g_wait
         state_t     state_reg;
         logic [2:0] cnt_reg;
         logic       gnt_reg;

         // gnt_reg is raised one cycle ahead so it is valid in the cycle req reaches GNT_WAIT held cycles
         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
               gnt_reg   <= 1'b0;
            end else begin
               case (state_reg)
                  ST_IDLE: begin
                     if (bus.data_req_in) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= 3'd1;
                        gnt_reg   <= (GNT_WAIT == 1);
                     end
                  end
                  ST_WAIT: begin
                     if (!bus.data_req_in || gnt_reg) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        gnt_reg   <= 1'b0;
                     end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                        gnt_reg <= ((cnt_reg + 3'd1) == 3'(GNT_WAIT));
                     end
                  end
                  default: begin
                     state_reg <= ST_IDLE;
                     cnt_reg   <= '0;
                     gnt_reg   <= 1'b0;
                  end
               endcase
            end
         end

         assign gnt = gnt_reg;
      end
   endgenerate

   logic [3:0][7:0] mem [DEPTH];
   logic [31:0]     ram_q_reg;

   // Reset blocks the write so a transaction accepted on the reset edge leaves the RAM untouched
   always_ff @(posedge clk) begin
      if (!rst && accept && bus.data_we_in && !out_of_range) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.data_be_in[b]) begin
               mem[word_idx][b] <= bus.data_wdata_in[8*b +: 8];
            end
         end
      end
      if (accept && !bus.data_we_in) begin
         ram_q_reg <= mem[word_idx];
      end
   end

   logic        s0_valid_reg;
   logic        s0_err_reg;
   logic        s0_read_reg;
   logic [31:0] s0_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_reg <= 1'b0;
         s0_err_reg   <= 1'b0;
         s0_read_reg  <= 1'b0;
      end else begin
         s0_valid_reg <= accept;
         s0_err_reg   <= accept & out_of_range;
         s0_read_reg  <= accept & !bus.data_we_in & !out_of_range;
      end
   end

   assign s0_data = s0_read_reg ? ram_q_reg : 32'd0;

   generate
      if (LATENCY == 1) begin : g_lat1
         assign bus.data_rvalid_o = s0_valid_reg;
         assign bus.data_err_o    = s0_err_reg;
         assign bus.data_rdata_o  = s0_data;
      end else begin : g_pipe
         logic        valid_reg [1:LATENCY-1];
         logic        err_reg   [1:LATENCY-1];
         logic [31:0] data_reg  [1:LATENCY-1];

         for (gi = 1; gi < LATENCY; gi++) begin : g_stage
            if (gi == 1) begin : g_first
               always_ff @(posedge clk) begin
                  if (rst) begin
                     valid_reg[gi] <= 1'b0;
                     err_reg[gi]   <= 1'b0;
                     data_reg[gi]  <= '0;
                  end else begin
                     valid_reg[gi] <= s0_valid_reg;
                     err_reg[gi]   <= s0_err_reg;
                     data_reg[gi]  <= s0_data;
                  end
               end
            end else begin : g_next
               always_ff @(posedge clk) begin
                  if (rst) begin
                     valid_reg[gi] <= 1'b0;
                     err_reg[gi]   <= 1'b0;
                     data_reg[gi]  <= '0;
                  end else begin
                     valid_reg[gi] <= valid_reg[gi-1];
                     err_reg[gi]   <= err_reg[gi-1];
                     data_reg[gi]  <= data_reg[gi-1];
                  end
               end
            end
         end

         assign bus.data_rvalid_o = valid_reg[LATENCY-1];
         assign bus.data_err_o    = err_reg[LATENCY-1];
         assign bus.data_rdata_o  = data_reg[LATENCY-1];
      end
   endgenerate
endmodule

// File: tb/tb_data_mem_responder.sv
// Three responders (LATENCY/GNT_WAIT = 1/0, 3/0, 3/2) driven by directed and random
// transactions; a word-array memory model and per-DUT response queues give expected values.
module tb_data_mem_responder;
   localparam int N_DUT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        drv_req   [N_DUT];
   logic [31:0] drv_add   [N_DUT];
   logic        drv_we    [N_DUT];
   logic [3:0]  drv_be    [N_DUT];
   logic [31:0] drv_wdata [N_DUT];
   logic        mon_gnt    [N_DUT];
   logic        mon_rvalid [N_DUT];
   logic        mon_err    [N_DUT];
   logic [31:0] mon_rdata  [N_DUT];

   genvar gi;
   generate
      for (gi = 0; gi < N_DUT; gi++) begin : g_dut
         data_mem_if bus();
         assign bus.data_req_in   = drv_req[gi];
         assign bus.data_add_in   = drv_add[gi];
         assign bus.data_we_in    = drv_we[gi];
         assign bus.data_be_in    = drv_be[gi];
         assign bus.data_wdata_in = drv_wdata[gi];
         assign mon_gnt[gi]       = bus.data_gnt_o;
         assign mon_rvalid[gi]    = bus.data_rvalid_o;
         assign mon_err[gi]       = bus.data_err_o;
         assign mon_rdata[gi]     = bus.data_rdata_o;

         data_mem_responder #(
            .ADDR_WIDTH(10),
            .LATENCY   ((gi == 0) ? 1 : 3),
            .GNT_WAIT  ((gi == 2) ? 2 : 0)
         ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
         );
      end
   endgenerate

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   logic [31:0] ref_mem [N_DUT][1024];
   int          exp_due [N_DUT][64];
   logic [33:0] exp_rsp [N_DUT][64];
   int          q_head  [N_DUT];
   int          q_tail  [N_DUT];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int wait_of(int i);
      return (i == 2) ? 2 : 0;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // Called just before the accepting edge: applies the access to the model and queues the response
   task automatic model_accept(int i, bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
      bit          oor;
      int          idx;
      logic [31:0] word;
      logic [31:0] data;
      oor  = (a >> 12) != 0;
      idx  = int'(a[11:2]);
      word = ref_mem[i][idx];
      data = 32'd0;
      if (!oor && we) begin
         for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
         ref_mem[i][idx] = word;
      end else if (!oor) begin
         data = word;
      end
      exp_due[i][q_tail[i] % 64] = cyc + lat_of(i);
      exp_rsp[i][q_tail[i] % 64] = {1'b1, oor, data};
      q_tail[i]++;
      $display("txn dut%0d %s addr=%h be=%b wdata=%h -> rsp err=%0d rdata=%h due cyc %0d",
               i, we ? "WR" : "RD", a, be, wd, oor, data, cyc + lat_of(i));
   endtask

   // Response monitor: every cycle each DUT must show exactly the queued response or all zeros
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < N_DUT; i++) begin
               logic [33:0] exp_v;
               exp_v = '0;
               if (q_head[i] != q_tail[i] && exp_due[i][q_head[i] % 64] == cyc) begin
                  exp_v = exp_rsp[i][q_head[i] % 64];
                  q_head[i]++;
               end
               check($sformatf("rsp%0d", i), 64'({mon_rvalid[i], mon_err[i], mon_rdata[i]}), 64'(exp_v));
            end
         end
      end
   end

   task automatic txn(int i, bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
      @(negedge clk);
      drv_req[i]   = 1'b1;
      drv_we[i]    = we;
      drv_add[i]   = a;
      drv_be[i]    = be;
      drv_wdata[i] = wd;
      for (int k = 1; k <= wait_of(i) + 1; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         check($sformatf("gnt%0d", i), 64'(mon_gnt[i]), 64'(k == wait_of(i) + 1));
         if (k == wait_of(i) + 1) model_accept(i, we, a, be, wd);
      end
      @(posedge clk);
      #1;
      drv_req[i] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N_DUT; i++) begin
         drv_req[i] = 1'b0; drv_add[i] = '0; drv_we[i] = 1'b0; drv_be[i] = '0; drv_wdata[i] = '0;
         q_head[i] = 0; q_tail[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      #1;
      for (int i = 0; i < N_DUT; i++) check($sformatf("rst_gnt%0d", i), 64'(mon_gnt[i]), 64'd0);

      // Fill a 16-word pool in each DUT so every later read has a known value
      for (int i = 0; i < N_DUT; i++)
         for (int w = 0; w < 16; w++) txn(i, 1'b1, 32'(w * 4), 4'hF, $urandom);

      // Basic write/read and byte-lane merge
      txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      txn(0, 1'b0, 32'h10, 4'hF, 32'h0);
      txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
      txn(0, 1'b1, 32'h22, 4'b0101, 32'hAABBCCDD);
      txn(0, 1'b0, 32'h20, 4'hF, 32'h0);
      txn(0, 1'b0, 32'h13, 4'hF, 32'h0);

      // Back-to-back reads through the 3-deep pipeline
      for (int w = 0; w < 8; w++) txn(1, 1'b0, 32'(w * 4), 4'hF, 32'h0);

      // Wait states, then a request abandoned mid-wait
      txn(2, 1'b0, 32'h14, 4'hF, 32'h0);
      @(negedge clk);
      drv_req[2] = 1'b1; drv_we[2] = 1'b1; drv_add[2] = 32'h14; drv_be[2] = 4'hF; drv_wdata[2] = 32'hCAFEF00D;
      #1 check("drop_gnt_c1", 64'(mon_gnt[2]), 64'd0);
      @(negedge clk);
      drv_req[2] = 1'b0;
      #1 check("drop_gnt_c2", 64'(mon_gnt[2]), 64'd0);
      @(negedge clk);
      #1 check("drop_gnt_c3", 64'(mon_gnt[2]), 64'd0);
      txn(2, 1'b0, 32'h14, 4'hF, 32'h0);

      // Out-of-range accesses; word 0 is the in-range alias of 0x1000
      txn(0, 1'b0, 32'h1000, 4'hF, 32'h0);
      txn(0, 1'b1, 32'h1000, 4'hF, 32'h55AA55AA);
      txn(0, 1'b0, 32'h0, 4'hF, 32'h0);
      txn(0, 1'b1, 32'h0, 4'b0000, 32'hFFFFFFFF);
      txn(0, 1'b0, 32'h0, 4'hF, 32'h0);

      // Reset with two reads in flight and a write presented on the reset edge
      txn(1, 1'b0, 32'h8, 4'hF, 32'h0);
      txn(1, 1'b0, 32'hC, 4'hF, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      drv_req[0] = 1'b1; drv_we[0] = 1'b1; drv_add[0] = 32'h30; drv_be[0] = 4'hF; drv_wdata[0] = ~ref_mem[0][12];
      #1;
      for (int i = 0; i < N_DUT; i++) q_head[i] = q_tail[i];
      @(posedge clk);
      #1;
      rst = 1'b0;
      drv_req[0] = 1'b0;
      txn(0, 1'b0, 32'h30, 4'hF, 32'h0);
      txn(1, 1'b0, 32'h8, 4'hF, 32'h0);

      // Random mix: pool addresses, random lanes, occasional out-of-range upper bits
      for (int i = 0; i < N_DUT; i++) begin
         for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 32'hFFFFF)) << 12);
            txn(i, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
         end
      end

      repeat (6) @(negedge clk);
      for (int i = 0; i < N_DUT; i++) check($sformatf("drain%0d", i), 64'(q_tail[i] - q_head[i]), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
